mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 31 +++
 rtl/mem_arb_timer.sv | 38 +++
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared CPU package: ALU opcodes plus the memory-arbiter state and grant types.
package mem_arbiter_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_SLT = 4'h5,
    ALU_SLL = 4'h6,
    ALU_SRL = 4'h7
  } alu_op_e;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_DM_BUSY = 2'd1,
    ARB_IF_BUSY = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_DM   = 2'd1,
    GRANT_IF   = 2'd2
  } grant_e;

  // Consecutive DM grants (with a fetch waiting) before the fetch is forced through.
  localparam logic [1:0] STARVE_LIMIT = 2'd2;
  localparam int WAIT_W = 4;

endpackage

// File: rtl/mem_arb_timer.sv
// Wait-state counter for the shared memory port; expire flags the busy cycle
// whose closing edge brings the count to MAX_WAIT.
module mem_arb_timer
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MAX_WAIT - 1);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data-memory requests onto one memory port,
// one transaction at a time, with a wait-state timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          stall,
  output logic          err,
  output arb_state_e    dbg_state
);

  arb_state_e    state_q, state_d;
  grant_e        grant;
  logic          end_txn;
  logic          expire;
  logic          timer_en;
  logic          timer_clr;
  logic          if_elig, dm_elig;
  logic [1:0]    starve_q, starve_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic          if_ack_q, if_ack_d;
  logic          dm_ack_q, dm_ack_d;
  logic          err_q, err_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic [DW-1:0] resp;

  // A requester still holding req during its own ack cycle is not re-served.
  assign if_elig = if_req && !if_ack_q;
  assign dm_elig = dm_req && !dm_ack_q;

  always_comb begin
    state_d = state_q;
    grant   = GRANT_NONE;
    end_txn = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (dm_elig && !(if_elig && (starve_q >= STARVE_LIMIT))) begin
          grant   = GRANT_DM;
          state_d = ARB_DM_BUSY;
        end else if (if_elig) begin
          grant   = GRANT_IF;
          state_d = ARB_IF_BUSY;
        end
      end
      ARB_DM_BUSY, ARB_IF_BUSY: begin
        if (mem_ready || expire) begin
          end_txn = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign timer_en  = (state_q != ARB_IDLE) && !mem_ready;
  assign timer_clr = (grant != GRANT_NONE);

  mem_arb_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (timer_clr),
    .enable_i (timer_en),
    .expire_o (expire)
  );

  // A timed-out transaction returns zero data.
  assign resp = mem_ready ? mem_rdata : '0;

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    starve_d    = starve_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (grant)
      GRANT_DM: begin
        mem_addr_d  = dm_addr;
        mem_wdata_d = dm_wdata;
        mem_we_d    = dm_we;
        if (!if_req) begin
          starve_d = '0;
        end else if (starve_q < STARVE_LIMIT) begin
          starve_d = starve_q + 2'd1;
        end
      end
      GRANT_IF: begin
        mem_addr_d  = if_addr;
        mem_wdata_d = '0;
        mem_we_d    = 1'b0;
        starve_d    = '0;
      end
      default: ;
    endcase
    if (end_txn) begin
      mem_we_d = 1'b0;
      err_d    = !mem_ready;
      if (state_q == ARB_IF_BUSY) begin
        if_ack_d   = 1'b1;
        if_rdata_d = resp;
      end else begin
        dm_ack_d   = 1'b1;
        dm_rdata_d = mem_we_q ? '0 : resp;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ARB_IDLE;
      starve_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign mem_en    = (state_q != ARB_IDLE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign err       = err_q;
  assign dbg_state = state_q;
  assign stall     = (if_req && !if_ack_q) || (dm_req && !dm_ack_q);

endmodule
